// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 instruction decode between fetch and register-read.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: 1-entry skid buffer absorbs a stalled output; in_ready is a registered !skid_valid.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          synchronous kill of the output register and skid entry
//   in_*           upstream valid/ready handshake with raw instruction and PC
//   out_*          downstream valid/ready handshake with the PC of the decoded entry
//   opcode..funct7 sliced instruction fields
//   fmt            0=R 1=I 2=S 3=B 4=U 5=J 6=ILL
//   imm            immediate sign-extended to XLEN (0 for R and ILL)
//   illegal        unrecognised encoding
//   perf_decoded, perf_illegal  transfer counters, present only when
//                  DECODE_STAGE_PERF_EN is defined
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
`ifdef DECODE_STAGE_PERF_EN
  ,
  output logic [31:0]     perf_decoded,
  output logic [31:0]     perf_illegal
`endif
);

  localparam bit IS_RV64 = (XLEN == 64);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } fmt_e;

  // One fully decoded entry; both the output register and the skid buffer
  // hold this so a skid-to-output move needs no re-decode.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    fmt_e            fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  localparam dec_t DEC_RST = '{
    pc:      '0,
    opcode:  '0,
    rd:      '0,
    rs1:     '0,
    rs2:     '0,
    funct3:  '0,
    funct7:  '0,
    fmt:     FMT_ILL,
    imm:     '0,
    illegal: 1'b0
  };

  dec_t        dec;
  dec_t        out_q;
  dec_t        skid_q;
  logic        out_vld_q;
  logic        skid_vld_q;
  logic [31:0] imm32;
  logic        in_xfer;
  logic        out_xfer;

  assign in_ready = !skid_vld_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_vld_q && out_ready;

  // ---------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------
  always_comb begin
    dec        = DEC_RST;
    imm32      = '0;
    dec.pc     = in_pc;
    dec.opcode = in_instr[6:0];
    dec.rd     = in_instr[11:7];
    dec.funct3 = in_instr[14:12];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct7 = in_instr[31:25];
    dec.fmt    = FMT_ILL;

    case (in_instr[6:0])
      7'b0110011:                     dec.fmt = FMT_R;
      7'b0111011: if (IS_RV64)        dec.fmt = FMT_R;
      7'b0010011, 7'b0000011,
      7'b1100111, 7'b1110011,
      7'b0001111:                     dec.fmt = FMT_I;
      7'b0011011: if (IS_RV64)        dec.fmt = FMT_I;
      7'b0100011:                     dec.fmt = FMT_S;
      7'b1100011:                     dec.fmt = FMT_B;
      7'b0110111, 7'b0010111:         dec.fmt = FMT_U;
      7'b1101111:                     dec.fmt = FMT_J;
      default:                        dec.fmt = FMT_ILL;
    endcase

    dec.illegal = (dec.fmt == FMT_ILL);

    // Every immediate is first formed as a sign-extended 32-bit value; the
    // widening to XLEN below repeats bit 31, which is instr[31] in every case.
    case (dec.fmt)
      FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: imm32 = {in_instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    dec.imm = XLEN'($signed(imm32));
  end

  // ---------------------------------------------------------------------
  // Output register and skid buffer
  // ---------------------------------------------------------------------
  // The skid only fills while the output register is full and stalled, and
  // in_ready is low whenever the skid is full, so an accept and a skid
  // refill can never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= DEC_RST;
      skid_q     <= DEC_RST;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (flush) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (!out_vld_q || out_xfer) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else if (in_xfer) begin
        out_q     <= dec;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q     <= dec;
      skid_vld_q <= 1'b1;
    end
  end

  assign out_valid = out_vld_q;
  assign out_pc    = out_q.pc;
  assign opcode    = out_q.opcode;
  assign rd        = out_q.rd;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign funct3    = out_q.funct3;
  assign funct7    = out_q.funct7;
  assign fmt       = out_q.fmt;
  assign imm       = out_q.imm;
  assign illegal   = out_q.illegal;

`ifdef DECODE_STAGE_PERF_EN
  // A transfer in a flush cycle is killed along with the entry, so it is
  // not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded <= '0;
      perf_illegal <= '0;
    end else if (out_xfer && !flush) begin
      perf_decoded <= perf_decoded + 32'd1;
      if (out_q.illegal) begin
        perf_illegal <= perf_illegal + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives an RV32 and an RV64 decode_stage with the same
// stream and compares both against a queue-based model of the stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  always #5 clk = ~clk;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_out_pc, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_funct3, a_fmt;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [63:0] b_out_pc, b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3, b_fmt;

`ifdef DECODE_STAGE_PERF_EN
  logic [31:0] a_perf_dec, a_perf_ill, b_perf_dec, b_perf_ill;
`endif

  decode_stage #(.XLEN(32), .PC_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .opcode(a_opcode), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2),
    .funct3(a_funct3), .funct7(a_funct7), .fmt(a_fmt), .imm(a_imm), .illegal(a_illegal)
`ifdef DECODE_STAGE_PERF_EN
    , .perf_decoded(a_perf_dec), .perf_illegal(a_perf_ill)
`endif
  );

  decode_stage #(.XLEN(64), .PC_W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .opcode(b_opcode), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2),
    .funct3(b_funct3), .funct7(b_funct7), .fmt(b_fmt), .imm(b_imm), .illegal(b_illegal)
`ifdef DECODE_STAGE_PERF_EN
    , .perf_decoded(b_perf_dec), .perf_illegal(b_perf_ill)
`endif
  );

  // ---------------------------------------------------------------------
  // Reference model: the stage is a FIFO of depth 2 whose head is shown
  // on the outputs; in_ready means "fewer than two held".
  // ---------------------------------------------------------------------
  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } ent_t;

  ent_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned m_dec = 0;
  int unsigned m_ill32 = 0;
  int unsigned m_ill64 = 0;

  logic [6:0] ops [13] = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                           7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] ins, input int xl,
                                  output logic [2:0] f, output logic [63:0] im,
                                  output logic ill);
    logic signed [63:0] s;
    s = 0;
    case (ins[6:0])
      7'h33:                      f = 3'd0;
      7'h3B:                      f = (xl == 64) ? 3'd0 : 3'd6;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: f = 3'd1;
      7'h1B:                      f = (xl == 64) ? 3'd1 : 3'd6;
      7'h23:                      f = 3'd2;
      7'h63:                      f = 3'd3;
      7'h37, 7'h17:               f = 3'd4;
      7'h6F:                      f = 3'd5;
      default:                    f = 3'd6;
    endcase
    case (f)
      3'd1: s = $signed(ins[31:20]);
      3'd2: s = $signed({ins[31:25], ins[11:7]});
      3'd3: s = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3'd4: s = $signed({ins[31:12], 12'h000});
      3'd5: s = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      default: s = 0;
    endcase
    im = s;
    if (xl == 32) im[63:32] = 32'h0;
    ill = (f == 3'd6);
  endfunction

  task automatic check_all();
    logic [2:0]  f;
    logic [63:0] im;
    logic        ill;
    chk("a_out_valid", a_out_valid, q.size() > 0);
    chk("a_in_ready",  a_in_ready,  q.size() < 2);
    chk("b_out_valid", b_out_valid, q.size() > 0);
    chk("b_in_ready",  b_in_ready,  q.size() < 2);
    if (q.size() > 0) begin
      ref_dec(q[0].ins, 32, f, im, ill);
      chk("a_fields", {a_funct7, a_rs2, a_rs1, a_funct3, a_rd, a_opcode}, q[0].ins);
      chk("a_pc", a_out_pc, q[0].pc[31:0]);
      chk("a_fmt", a_fmt, f);
      chk("a_imm", a_imm, im);
      chk("a_illegal", a_illegal, ill);
      ref_dec(q[0].ins, 64, f, im, ill);
      chk("b_fields", {b_funct7, b_rs2, b_rs1, b_funct3, b_rd, b_opcode}, q[0].ins);
      chk("b_pc", b_out_pc, q[0].pc);
      chk("b_fmt", b_fmt, f);
      chk("b_imm", b_imm, im);
      chk("b_illegal", b_illegal, ill);
    end
`ifdef DECODE_STAGE_PERF_EN
    chk("a_perf_dec", a_perf_dec, m_dec);
    chk("a_perf_ill", a_perf_ill, m_ill32);
    chk("b_perf_dec", b_perf_dec, m_dec);
    chk("b_perf_ill", b_perf_ill, m_ill64);
`endif
  endtask

  // One clock: apply inputs, advance the model, then check just after the edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic        acc;
    logic        drn;
    logic [2:0]  f;
    logic [63:0] im;
    logic        ill;
    logic [63:0] pc;
    pc        = {$urandom, $urandom};
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    if (fl) begin
      q.delete();
    end else begin
      if (drn) begin
        m_dec++;
        ref_dec(q[0].ins, 32, f, im, ill);
        if (ill) m_ill32++;
        ref_dec(q[0].ins, 64, f, im, ill);
        if (ill) m_ill64++;
        void'(q.pop_front());
      end
      if (acc) q.push_back('{ins, pc});
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_valid"}, a_out_valid, 1'b0);
    chk({tag, "_a_ready"}, a_in_ready, 1'b1);
    chk({tag, "_a_fmt"}, a_fmt, 3'd6);
    chk({tag, "_a_data"}, {a_out_pc, a_opcode, a_rd, a_rs1, a_rs2, a_funct3, a_funct7, a_imm, a_illegal}, 64'h0);
    chk({tag, "_b_valid"}, b_out_valid, 1'b0);
    chk({tag, "_b_fmt"}, b_fmt, 3'd6);
    chk({tag, "_b_imm"}, b_imm, 64'h0);
    chk({tag, "_b_pc"}, b_out_pc, 64'h0);
  endtask

  // Known instructions: one accepted-and-shown cycle with constant expectations.
  task automatic dir(input string tag, input logic [31:0] ins,
                     input logic [2:0] f32, input logic [2:0] f64,
                     input logic [31:0] im32, input logic [63:0] im64);
    cycle(1'b1, ins, 1'b1, 1'b0);
    chk({tag, "_a_fmt"}, a_fmt, f32);
    chk({tag, "_b_fmt"}, b_fmt, f64);
    chk({tag, "_a_imm"}, a_imm, im32);
    chk({tag, "_b_imm"}, b_imm, im64);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 13) r[6:0] = ops[k];
    return r;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode vectors
    dir("addi", 32'hFFF00093, 3'd1, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    chk("addi_opcode", a_opcode, 7'h13);
    chk("addi_rd", a_rd, 5'd1);
    chk("addi_rs1", a_rs1, 5'd0);
    chk("addi_illegal", a_illegal, 1'b0);
    dir("sw", 32'h00112623, 3'd2, 3'd2, 32'h0000000C, 64'h000000000000000C);
    chk("sw_rs1", a_rs1, 5'd2);
    chk("sw_rs2", a_rs2, 5'd1);
    chk("sw_funct3", a_funct3, 3'd2);
    dir("beq", 32'hFE000EE3, 3'd3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    dir("lui", 32'h123450B7, 3'd4, 3'd4, 32'h12345000, 64'h0000000012345000);
    dir("luineg", 32'h800000B7, 3'd4, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000);
    dir("jal", 32'hFFDFF0EF, 3'd5, 3'd5, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    dir("zero", 32'h00000000, 3'd6, 3'd6, 32'h0, 64'h0);
    chk("zero_illegal", a_illegal, 1'b1);
    dir("addw", 32'h0000003B, 3'd6, 3'd0, 32'h0, 64'h0);
    dir("addiw", 32'hFFF0009B, 3'd6, 3'd1, 32'h0, 64'hFFFFFFFFFFFFFFFF);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef DECODE_STAGE_PERF_EN
    chk("perf_ill_nonzero", b_perf_ill, 32'd1);
`endif

    // Backpressure: A held, B in skid, C held upstream
    cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 1'b0, 1'b0);
    chk("bp_in_ready", a_in_ready, 1'b0);
    chk("bp_head", a_rd, 5'd1);
    cycle(1'b1, 32'h00300193, 1'b0, 1'b0);
    chk("bp_hold", a_rd, 5'd1);
    cycle(1'b1, 32'h00300193, 1'b1, 1'b0);
    chk("bp_second", a_rd, 5'd2);
    cycle(1'b1, 32'h00300193, 1'b1, 1'b0);
    chk("bp_third", a_rd, 5'd3);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_empty", a_out_valid, 1'b0);

    // Flush with two entries held, plus an input offered in the flush cycle
    cycle(1'b1, 32'h00400213, 1'b0, 1'b0);
    cycle(1'b1, 32'h00500293, 1'b0, 1'b0);
    cycle(1'b1, 32'h00600313, 1'b1, 1'b1);
    chk("flush_valid", a_out_valid, 1'b0);
    chk("flush_ready", b_in_ready, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset while entries are held and a transfer is offered
    cycle(1'b1, rand_instr(), 1'b0, 1'b0);
    cycle(1'b1, rand_instr(), 1'b0, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_dec = 0;
    m_ill32 = 0;
    m_ill64 = 0;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle($urandom_range(0, 1) != 0, rand_instr(), $urandom_range(0, 1) != 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name:
decode_stage

Overview:
- Registered RV32/RV64 instruction decode stage between fetch and register-read.
- Slices instruction fields, classifies the format, generates the sign-extended immediate, and flags illegal encodings.
- Full valid/ready handshake on both sides, with a 1-entry skid buffer so that `in_ready` is driven from a register.
- Generalised in XLEN and in opcode set; the earlier field-splitter had no state, immediate generation, or legality check.

Parameters:
- XLEN, 32, datapath width: 32 or 64. 64 enables OP-IMM-32 (0011011) and OP-32 (0111011).
- PC_W, XLEN, width of the PC carried alongside the instruction.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  PC of decoded entry
- opcode  out  7  instr[6:0]
- rd  out  5  instr[11:7]
- rs1  out  5  instr[19:15]
- rs2  out  5  instr[24:20]
- funct3  out  3  instr[14:12]
- funct7  out  7  instr[31:25]
- fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=ILL
- imm  out  XLEN  sign-extended immediate
- illegal  out  1  unrecognised encoding

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, skid empty, in_ready=1.
  - All data outputs 0; fmt=6.
- Transfers:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
- Latency: 1 cycle. An instruction accepted in cycle N appears on the outputs in cycle N+1.
- in_ready = !skid_valid.
- Output register and skid buffer:
  - An accepted instruction is decoded combinationally and written to the output register when that register is empty or draining this cycle.
  - Otherwise it is written to the skid buffer.
  - When the output register drains and the skid buffer is full, the skid entry moves to the output register.
  - Ordering is strictly preserved; no entry is dropped or duplicated.
- Output hold: while out_valid & !out_ready, every output is stable.
- flush (has priority over every other event in the same cycle):
  - Next cycle: out_valid=0 and skid empty.
  - Any input accepted in the flush cycle is discarded.
  - in_ready=1 in the cycle after flush.
- Format classification by opcode (instr[1:0] must be 11):
  - R: 0110011, plus 0111011 when XLEN=64.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111, plus 0011011 when XLEN=64.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Anything else: fmt=6, illegal=1, imm=0. Other fields are still sliced.
- Immediate generation, sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended above bit 31 for XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: imm=0.
- Reset asserted mid-transfer: all state cleared immediately, regardless of the handshake.

Optional Feature:
- Macro: DECODE_STAGE_PERF_EN.
- Defined:
  - Adds output ports perf_decoded[31:0] and perf_illegal[31:0], both reset to 0.
  - perf_decoded increments on every output transfer; perf_illegal increments on every output transfer with illegal=1.
  - Both counters wrap at 2^32-1 to 0.
  - Flushed entries are not counted.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- XLEN=32, out_ready=1; send 0xFFF00093 (addi x1,x0,-1).
  - Next cycle: out_valid=1, opcode=0x13, rd=1, rs1=0, fmt=1, imm=0xFFFFFFFF, illegal=0.
- Send 0x00112623 (sw x1,12(x2)) -> fmt=2, rs1=2, rs2=1, funct3=2, imm=0x0000000C.
- Send 0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=0xFFFFFFFC.
- XLEN=64; send 0x123450B7 (lui) -> fmt=4, imm=0x0000000012345000.
  - Then send 0x800000B7 -> imm=0xFFFFFFFF80000000.
- Send 0x00000000 -> fmt=6, illegal=1, imm=0.
  - With DECODE_STAGE_PERF_EN: perf_illegal=1 after the transfer.
- Backpressure and flush sequence:
  - Hold out_ready=0 while streaming 3 instructions A, B, C -> A is held on the outputs, B is in the skid buffer, in_ready=0, C is held upstream.
  - Release out_ready -> outputs A, B, C in order, with no loss or duplicate.
  - Repeat with flush asserted while 2 entries are held -> out_valid=0 and in_ready=1 next cycle; the flushed entries never appear.
